// File: rtl/divisor_tick_pkg.sv
// Shared state encoding and parameter defaults for the divisor_tick block.
package divisor_tick_pkg;

  localparam int W_DEFAULT           = 8;
  localparam int DIV_DEFAULT_DEFAULT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : divisor_tick_pkg

// File: rtl/divisor_tick_detector_flanco.sv
// Rising-edge detector for the in_clk level; rise is combinational from the current sample.
// prev resets high to match the upstream divider's reset-high output.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic in_clk,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= in_clk;
    end
  end

  assign rise = in_clk & ~prev_q;

endmodule : detector_flanco

// File: rtl/divisor_tick.sv
// Counts in_clk rising edges and emits a registered one-cycle tick every `limit` edges,
// toggling out_div on each tick; a load strobe re-arms the ratio and takes priority over edges.
module divisor_tick
  import divisor_tick_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_clk,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div_val,
  output logic         tick,
  output logic         out_div,
  output logic         busy
);

  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] LIMIT_RST = (DIV_DEFAULT == 0) ? W'(1) : W'(DIV_DEFAULT);

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] limit_q, limit_d;
  logic         tick_q, tick_d;
  logic         out_div_q, out_div_d;
  logic         rise;
  logic         count_en;

  detector_flanco u_detector (
    .clk    (clk),
    .reset  (reset),
    .in_clk (in_clk),
    .rise   (rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      limit_q   <= LIMIT_RST;
      tick_q    <= 1'b0;
      out_div_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      tick_q    <= tick_d;
      out_div_q <= out_div_d;
    end
  end

  // Edges are only counted while running and enabled; a coincident load discards the edge.
  assign count_en = (state_q == RUN) && en && rise && !load;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    tick_d    = 1'b0;
    out_div_d = out_div_q;

    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      limit_d = (div_val == '0) ? ONE : div_val;
      count_d = '0;
    end else if (count_en) begin
      if (count_q == limit_q - ONE) begin
        count_d   = '0;
        tick_d    = 1'b1;
        out_div_d = ~out_div_q;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  assign tick    = tick_q;
  assign out_div = out_div_q;
  assign busy    = (state_q == RUN);

endmodule : divisor_tick

// File: tb/tb_divisor_tick.sv
// Self-checking bench for divisor_tick: vector table for the default ratio, then model-scored corner sequences.
module tb_divisor_tick;
  import divisor_tick_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_clk;
  logic         en;
  logic         load;
  logic [W-1:0] div_val;
  logic         tick;
  logic         out_div;
  logic         busy;

  divisor_tick #(.W(W), .DIV_DEFAULT(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_clk  (in_clk),
    .en      (en),
    .load    (load),
    .div_val (div_val),
    .tick    (tick),
    .out_div (out_div),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic tick;
    logic out_div;
    logic busy;
  } exp_t;

  typedef struct packed {
    logic         in_clk;
    logic         en;
    logic         ld;
    logic [W-1:0] dv;
    logic         tick;
    logic         out_div;
    logic         busy;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[12];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_tick = -1;
  int tick_gap  = 0;
  int n_ticks   = 0;
  logic lvl;
  logic en_cur;

  // Reference model state
  logic         m_state;
  logic         m_prev;
  logic [W-1:0] m_count;
  logic [W-1:0] m_limit;
  logic         m_tick;
  logic         m_out;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task model_reset();
    m_state = 1'b0;
    m_prev  = 1'b1;
    m_count = '0;
    m_limit = W'(2);
    m_tick  = 1'b0;
    m_out   = 1'b0;
  endtask

  task model_step(input logic i_in, input logic i_en, input logic i_ld, input logic [W-1:0] i_dv);
    logic r;
    logic nt;
    r  = i_in & ~m_prev;
    nt = 1'b0;
    if (i_ld) begin
      m_limit = (i_dv == 0) ? W'(1) : i_dv;
      m_count = '0;
    end else if (m_state && i_en && r) begin
      if (m_count == m_limit - W'(1)) begin
        m_count = '0;
        nt      = 1'b1;
        m_out   = ~m_out;
      end else begin
        m_count = m_count + W'(1);
      end
    end
    m_state = i_en;
    m_prev  = i_in;
    m_tick  = nt;
  endtask

  // Drive one cycle of inputs, push the expectation, then pop and compare after the edge.
  task automatic step(input logic i_in, input logic i_en, input logic i_ld,
                      input logic [W-1:0] i_dv, input bit use_tbl, input exp_t tbl_exp);
    exp_t e;
    in_clk  = i_in;
    en      = i_en;
    load    = i_ld;
    div_val = i_dv;
    lvl     = i_in;
    model_step(i_in, i_en, i_ld, i_dv);
    if (use_tbl) sb_q.push_back(tbl_exp);
    else         sb_q.push_back('{m_tick, m_out, m_state});
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty at cycle %0d: no expectation queued", cyc);
    end else begin
      e = sb_q.pop_front();
      check1("tick", tick, e.tick);
      check1("out_div", out_div, e.out_div);
      check1("busy", busy, e.busy);
    end
    if (tick === 1'b1) begin
      if (last_tick >= 0) tick_gap = cyc - last_tick;
      last_tick = cyc;
      n_ticks++;
    end
  endtask

  task automatic tog(input int n);
    for (int k = 0; k < n; k++) step(~lvl, en_cur, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    //           in    en    ld    dv     tick  out   busy
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1};

    reset   = 1'b0;
    in_clk  = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    div_val = '0;
    lvl     = 1'b1;
    en_cur  = 1'b1;
    #2 reset = 1'b1;
    #1;
    check1("reset_tick", tick, 1'b0);
    check1("reset_out_div", out_div, 1'b0);
    check1("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Default ratio 2, in_clk toggling every cycle.
    for (int i = 0; i < 12; i++)
      step(tbl[i].in_clk, tbl[i].en, tbl[i].ld, tbl[i].dv, 1'b1,
           '{tbl[i].tick, tbl[i].out_div, tbl[i].busy});
    check_int("ratio2_tick_gap", tick_gap, 4);

    // Ratio 3.
    step(1'b0, 1'b1, 1'b1, 8'd3, 1'b0, '0);
    tog(14);
    check_int("ratio3_tick_gap", tick_gap, 6);

    // div_val=0 behaves as ratio 1.
    step(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, '0);
    n0 = n_ticks;
    tog(8);
    check_int("ratio1_tick_count", n_ticks - n0, 4);
    check_int("ratio1_tick_gap", tick_gap, 2);

    // Load coincident with the terminal rise: edge discarded, new limit 4 takes over.
    step(1'b0, 1'b1, 1'b1, 8'd2, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, '0);
    check1("load_rise_no_tick", tick, 1'b0);
    n0 = n_ticks;
    tog(7);
    check_int("limit4_no_early_tick", n_ticks - n0, 0);
    tog(1);
    check1("limit4_tick_on_4th_rise", tick, 1'b1);

    // en dropped for 10 cycles at count=1 with ratio 3.
    step(1'b0, 1'b1, 1'b1, 8'd3, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, '0);
    en_cur = 1'b0;
    n0 = n_ticks;
    tog(10);
    check_int("en_low_no_tick", n_ticks - n0, 0);
    check1("en_low_busy", busy, 1'b0);
    en_cur = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0);
    tog(2);
    check1("en_resume_no_early_tick", tick, 1'b0);
    tog(1);
    check1("en_resume_tick", tick, 1'b1);

    // Run until out_div is high mid-count, then reset asynchronously.
    for (int k = 0; k < 20 && !(m_out && m_count != 0); k++) tog(1);
    check1("pre_reset_out_div", out_div, 1'b1);
    #2 reset = 1'b1;
    #1;
    check1("async_reset_tick", tick, 1'b0);
    check1("async_reset_out_div", out_div, 1'b0);
    check1("async_reset_busy", busy, 1'b0);
    in_clk = 1'b1;
    lvl    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0);
    check1("post_reset_first_tick", tick, 1'b0);
    tog(12);
    check_int("post_reset_default_gap", tick_gap, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_divisor_tick
